// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/load write-back requests and register-file write port
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_Reg;
  logic [DATA_W-1:0] Write_Bus;
  logic              grant_src;
  logic [3:0]        wait_cnt;
  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, RegWrite, Write_Reg, Write_Bus, grant_src, wait_cnt
  );
  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, RegWrite, Write_Reg, Write_Bus, grant_src, wait_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: load-priority arbiter for the register-file write port with ALU starvation guard
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);
  logic alu_go, mem_go;
  logic [3:0] wait_q;
  always_comb begin
    mem_go = rst_n && bus.mem_valid && !(bus.alu_valid && wait_q >= 4'(MAX_WAIT));
    alu_go = rst_n && bus.alu_valid && !mem_go;
  end
  assign bus.alu_ready = alu_go;
  assign bus.mem_ready = mem_go;
  assign bus.wait_cnt  = wait_q;
  // register 0 is hardwired zero: accept the transfer but suppress the write enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.RegWrite  <= 1'b0;
      bus.Write_Reg <= '0;
      bus.Write_Bus <= '0;
      bus.grant_src <= 1'b0;
      wait_q        <= '0;
    end else begin
      bus.RegWrite <= (alu_go && bus.alu_reg != '0) || (mem_go && bus.mem_reg != '0);
      if (alu_go || mem_go) begin
        bus.Write_Reg <= mem_go ? bus.mem_reg : bus.alu_reg;
        bus.Write_Bus <= mem_go ? bus.mem_data : bus.alu_data;
        bus.grant_src <= mem_go;
      end
      wait_q <= (alu_go || !bus.alu_valid) ? 4'd0 : (wait_q == 4'd15 ? 4'd15 : wait_q + 4'd1);
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) b ();
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    b.alu_valid = 1'b0;
    b.mem_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    b.alu_valid = 1'b1; b.alu_reg = 5'd9; b.alu_data = 32'h22;
    b.mem_valid = 1'b1; b.mem_reg = 5'd7; b.mem_data = 32'h11;
    tick;
    tick;
    total++; if (b.RegWrite !== 1'b0) $display("FAIL reset_regwrite got %0h exp 0", b.RegWrite); else passed++;
    total++; if (b.alu_ready !== 1'b0) $display("FAIL reset_alu_ready got %0h exp 0", b.alu_ready); else passed++;
    total++; if (b.mem_ready !== 1'b0) $display("FAIL reset_mem_ready got %0h exp 0", b.mem_ready); else passed++;
    total++; if (b.Write_Reg !== 5'd0) $display("FAIL reset_write_reg got %0h exp 0", b.Write_Reg); else passed++;
    total++; if (b.Write_Bus !== 32'd0) $display("FAIL reset_write_bus got %0h exp 0", b.Write_Bus); else passed++;
    total++; if (b.wait_cnt !== 4'd0) $display("FAIL reset_wait_cnt got %0h exp 0", b.wait_cnt); else passed++;
    total++; if (b.grant_src !== 1'b0) $display("FAIL reset_grant_src got %0h exp 0", b.grant_src); else passed++;
    idle;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_single_alu;
    b.alu_valid = 1'b1; b.alu_reg = 5'd5; b.alu_data = 32'hDEADBEEF;
    #1;
    total++; if (b.alu_ready !== 1'b1) $display("FAIL single_alu_ready got %0h exp 1", b.alu_ready); else passed++;
    total++; if (b.mem_ready !== 1'b0) $display("FAIL single_mem_ready got %0h exp 0", b.mem_ready); else passed++;
    tick;
    idle;
    total++; if (b.RegWrite !== 1'b1) $display("FAIL single_regwrite got %0h exp 1", b.RegWrite); else passed++;
    total++; if (b.Write_Reg !== 5'd5) $display("FAIL single_write_reg got %0h exp 5", b.Write_Reg); else passed++;
    total++; if (b.Write_Bus !== 32'hDEADBEEF) $display("FAIL single_write_bus got %0h exp deadbeef", b.Write_Bus); else passed++;
    total++; if (b.grant_src !== 1'b0) $display("FAIL single_grant_src got %0h exp 0", b.grant_src); else passed++;
    tick;
    total++; if (b.RegWrite !== 1'b0) $display("FAIL single_regwrite_drop got %0h exp 0", b.RegWrite); else passed++;
    total++; if (b.Write_Reg !== 5'd5) $display("FAIL single_write_reg_hold got %0h exp 5", b.Write_Reg); else passed++;
  endtask
  task automatic test_contention;
    b.alu_valid = 1'b1; b.alu_reg = 5'd9; b.alu_data = 32'h22;
    b.mem_valid = 1'b1; b.mem_reg = 5'd7; b.mem_data = 32'h11;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (b.wait_cnt !== 4'(i)) $display("FAIL cont_wait_cnt[%0d] got %0d exp %0d", i, b.wait_cnt, i); else passed++;
      total++; if (b.mem_ready !== (i < 3)) $display("FAIL cont_mem_ready[%0d] got %0h exp %0h", i, b.mem_ready, i < 3); else passed++;
      total++; if (b.alu_ready !== (i == 3)) $display("FAIL cont_alu_ready[%0d] got %0h exp %0h", i, b.alu_ready, i == 3); else passed++;
      tick;
      total++; if (b.RegWrite !== 1'b1) $display("FAIL cont_regwrite[%0d] got %0h exp 1", i, b.RegWrite); else passed++;
      total++; if (b.Write_Reg !== (i < 3 ? 5'd7 : 5'd9)) $display("FAIL cont_write_reg[%0d] got %0d exp %0d", i, b.Write_Reg, i < 3 ? 7 : 9); else passed++;
      total++; if (b.Write_Bus !== (i < 3 ? 32'h11 : 32'h22)) $display("FAIL cont_write_bus[%0d] got %0h exp %0h", i, b.Write_Bus, i < 3 ? 32'h11 : 32'h22); else passed++;
      total++; if (b.grant_src !== (i < 3)) $display("FAIL cont_grant_src[%0d] got %0h exp %0h", i, b.grant_src, i < 3); else passed++;
    end
    total++; if (b.wait_cnt !== 4'd0) $display("FAIL cont_wait_clear got %0d exp 0", b.wait_cnt); else passed++;
    idle;
    tick;
  endtask
  task automatic test_reg0;
    b.mem_valid = 1'b1; b.mem_reg = 5'd0; b.mem_data = 32'hFFFFFFFF;
    #1;
    total++; if (b.mem_ready !== 1'b1) $display("FAIL reg0_mem_ready got %0h exp 1", b.mem_ready); else passed++;
    tick;
    idle;
    total++; if (b.RegWrite !== 1'b0) $display("FAIL reg0_regwrite got %0h exp 0", b.RegWrite); else passed++;
    total++; if (b.Write_Reg !== 5'd0) $display("FAIL reg0_write_reg got %0h exp 0", b.Write_Reg); else passed++;
    total++; if (b.Write_Bus !== 32'hFFFFFFFF) $display("FAIL reg0_write_bus got %0h exp ffffffff", b.Write_Bus); else passed++;
    total++; if (b.grant_src !== 1'b1) $display("FAIL reg0_grant_src got %0h exp 1", b.grant_src); else passed++;
    tick;
  endtask
  task automatic test_reset_mid;
    b.alu_valid = 1'b1; b.alu_reg = 5'd9; b.alu_data = 32'h22;
    b.mem_valid = 1'b1; b.mem_reg = 5'd7; b.mem_data = 32'h11;
    tick;
    tick;
    total++; if (b.wait_cnt !== 4'd2) $display("FAIL mid_wait_before got %0d exp 2", b.wait_cnt); else passed++;
    rst_n = 1'b0;
    tick;
    total++; if (b.wait_cnt !== 4'd0) $display("FAIL mid_wait_cnt got %0d exp 0", b.wait_cnt); else passed++;
    total++; if (b.RegWrite !== 1'b0) $display("FAIL mid_regwrite got %0h exp 0", b.RegWrite); else passed++;
    total++; if (b.Write_Bus !== 32'd0) $display("FAIL mid_write_bus got %0h exp 0", b.Write_Bus); else passed++;
    total++; if (b.mem_ready !== 1'b0) $display("FAIL mid_mem_ready_rst got %0h exp 0", b.mem_ready); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (b.mem_ready !== 1'b1) $display("FAIL mid_mem_first got %0h exp 1", b.mem_ready); else passed++;
    total++; if (b.alu_ready !== 1'b0) $display("FAIL mid_alu_held got %0h exp 0", b.alu_ready); else passed++;
    tick;
    total++; if (b.grant_src !== 1'b1) $display("FAIL mid_grant_src got %0h exp 1", b.grant_src); else passed++;
    total++; if (b.Write_Reg !== 5'd7) $display("FAIL mid_write_reg got %0d exp 7", b.Write_Reg); else passed++;
    total++; if (b.wait_cnt !== 4'd1) $display("FAIL mid_wait_after got %0d exp 1", b.wait_cnt); else passed++;
    idle;
    tick;
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      b.alu_valid = 1'b1; b.alu_reg = 5'(i + 1); b.alu_data = 32'(32'hA + i);
      tick;
      total++; if (b.RegWrite !== 1'b1) $display("FAIL b2b_regwrite[%0d] got %0h exp 1", i, b.RegWrite); else passed++;
      total++; if (b.Write_Reg !== 5'(i + 1)) $display("FAIL b2b_write_reg[%0d] got %0d exp %0d", i, b.Write_Reg, i + 1); else passed++;
      total++; if (b.Write_Bus !== 32'(32'hA + i)) $display("FAIL b2b_write_bus[%0d] got %0h exp %0h", i, b.Write_Bus, 32'hA + i); else passed++;
    end
    idle;
    tick;
    total++; if (b.RegWrite !== 1'b0) $display("FAIL b2b_regwrite_end got %0h exp 0", b.RegWrite); else passed++;
  endtask
  initial begin
    idle;
    b.alu_reg = '0; b.alu_data = '0; b.mem_reg = '0; b.mem_data = '0;
    test_reset;
    test_single_alu;
    test_contention;
    test_reg0;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two write-back requesters: the ALU result path and the memory/load return path.
- Arbitrates with a valid/ready handshake per requester, one grant per cycle.
- Registers the winning request onto RegWrite / Write_Reg / Write_Bus for the 32-entry, 32-bit register file.
- Load path has default priority; a starvation counter guarantees ALU forward progress.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- MAX_WAIT, 3, consecutive cycles ALU may be denied while valid before it is force-granted (range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- alu_valid  input  1  ALU write-back request.
- alu_reg  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU write data.
- alu_ready  output  1  ALU request accepted this cycle.
- mem_valid  input  1  load write-back request.
- mem_reg  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load write data.
- mem_ready  output  1  load request accepted this cycle.
- RegWrite  output  1  register-file write enable.
- Write_Reg  output  ADDR_W  register-file write address.
- Write_Bus  output  DATA_W  register-file write data.
- grant_src  output  1  source of the current RegWrite: 0 = ALU, 1 = MEM.
- wait_cnt  output  4  current ALU starvation count, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on rst_n; sampled on the rising edge of clk.
- Reset values:
  - RegWrite=0, Write_Reg=0, Write_Bus=0, grant_src=0, wait_cnt=0.
  - alu_ready and mem_ready are 0 while rst_n=0.
- Transfer rule:
  - A transfer occurs on a requester when valid and ready are both high at a rising edge.
  - ready is combinational from valid and wait_cnt; no combinational path from ready back to valid.
  - A requester holds valid, reg and data stable until its transfer.
- Grant decision, per cycle, with only one ready high at a time:
  - neither valid: no grant.
  - only alu_valid: alu_ready=1.
  - only mem_valid: mem_ready=1.
  - both valid, wait_cnt < MAX_WAIT: mem_ready=1.
  - both valid, wait_cnt >= MAX_WAIT: alu_ready=1 (forced).
- Starvation counter, updated every edge:
  - alu_valid=1 and ALU not granted: wait_cnt+1, saturating at 15.
  - ALU granted, or alu_valid=0: wait_cnt=0.
- Output register, latency 1 cycle:
  - A transfer at edge N drives Write_Reg/Write_Bus/grant_src with the winner's fields after edge N.
  - RegWrite=1 for exactly that cycle.
  - With no transfer at an edge: RegWrite=0 next cycle; Write_Reg, Write_Bus and grant_src hold their previous values.
- Register 0: a transfer with reg=0 is accepted (ready=1, counts as a grant for wait_cnt) but produces RegWrite=0. Write_Reg/Write_Bus still update. Register 0 is hardwired zero and is never written.
- Back-to-back transfers: one per cycle is sustained. Each transfer's RegWrite cycle is independent; no bubbles are inserted.
- Same destination from both sources in the same cycle: both are serialized in grant order. The later grant's data lands last.
- Reset mid-operation: rst_n=0 at any edge clears all outputs and wait_cnt at that edge. A request pending at reset is not written; the requester re-presents after reset.
- No internal buffering beyond the single output register; throughput is bounded by the one write port.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both valids high -> RegWrite=0, both readys=0, Write_Reg=0, Write_Bus=0, wait_cnt=0.
- Single ALU: alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle. Next cycle RegWrite=1, Write_Reg=5, Write_Bus=0xDEADBEEF, grant_src=0. The following cycle RegWrite=0.
- Contention, MAX_WAIT=3: both valid continuously, mem_reg=7, mem_data=0x11, alu_reg=9, alu_data=0x22 ->
  - mem granted 3 cycles while wait_cnt goes 1,2,3.
  - 4th cycle alu_ready=1, then wait_cnt=0.
  - RegWrite stream: 7,7,7,9 with grant_src 1,1,1,0.
- Register 0 drop: mem_valid=1, mem_reg=0, mem_data=0xFFFFFFFF -> mem_ready=1; next cycle RegWrite=0, Write_Reg=0, Write_Bus=0xFFFFFFFF.
- Reset mid-contention: both valid, wait_cnt=2, assert rst_n=0 for one edge -> wait_cnt=0, RegWrite=0. After release, mem is granted first again.
- Back-to-back ALU: alu_valid=1 for 4 cycles with reg 1,2,3,4 and data 0xA..0xD -> RegWrite=1 for 4 consecutive cycles, Write_Reg 1,2,3,4 in order, no gaps.
